// File: rtl/gray_rptr_empty.sv
// Read-domain pointer stage of the async FIFO: binary/Gray read pointer, write-pointer synchronizer, registered empty.
// Optional feature macro GRAY_RPTR_LEVEL_EN adds the registered rd_level occupancy output.
module gray_rptr_empty #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW:0]   wptr_gray_async,
    output logic [AW-1:0] raddr,
    output logic [AW:0]   rptr_gray,
`ifdef GRAY_RPTR_LEVEL_EN
    output logic [AW:0]   rd_level,
`endif
    output logic          empty
);

    localparam int unsigned PW = AW + 1;

    logic [AW:0] rbin;
    logic [AW:0] rgray;
    logic [AW:0] wq1;
    logic [AW:0] wq2;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_next;
    logic        rinc;

    // Reads are only accepted while data is known to be present.
    always_comb begin
        rinc       = rd_en & ~empty;
        rbin_next  = rbin + PW'(rinc);
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    // Empty uses the next read pointer so the last-entry read closes the flag at its own edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
            empty <= 1'b1;
        end else begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
            wq1   <= wptr_gray_async;
            wq2   <= wq1;
            empty <= (rgray_next == wq2);
        end
    end

    assign raddr     = rbin[AW-1:0];
    assign rptr_gray = rgray;

`ifdef GRAY_RPTR_LEVEL_EN
    logic [AW:0] wbin_s;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wbin_s[i] = ^(wq2 >> i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_level <= '0;
        end else begin
            rd_level <= wbin_s - rbin_next;
        end
    end
`endif

endmodule

// File: tb/tb_gray_rptr_empty.sv
// Scoreboard bench for gray_rptr_empty: reset, sync latency, burst, wrap, read-while-empty, simultaneous update.
module tb_gray_rptr_empty;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   wptr_gray_async = '0;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr_gray;
    logic          empty;
`ifdef GRAY_RPTR_LEVEL_EN
    logic [AW:0]   rd_level;
`endif

    gray_rptr_empty #(.AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wptr_gray_async (wptr_gray_async),
        .raddr           (raddr),
        .rptr_gray       (rptr_gray),
`ifdef GRAY_RPTR_LEVEL_EN
        .rd_level        (rd_level),
`endif
        .empty           (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW:0]   gray;
        logic [AW-1:0] addr;
        logic          empty;
        logic [AW:0]   level;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [AW:0] m_rbin, m_wq1, m_wq2, m_level;
    logic        m_empty;
    logic [AW:0] wb = '0;

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] from_gray(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_clear();
        m_rbin = '0; m_wq1 = '0; m_wq2 = '0; m_level = '0; m_empty = 1'b1;
        sb.delete();
    endtask

    // One clock: drive at the current negedge, advance the model at posedge, return at next negedge.
    task automatic cyc(input logic rd);
        logic        rinc;
        logic [AW:0] nb;
        exp_t        x;
        rd_en = rd;
        wptr_gray_async = to_gray(wb);
        @(posedge clk);
        rinc    = rd_en & ~m_empty;
        nb      = m_rbin + {{AW{1'b0}}, rinc};
        m_empty = (to_gray(nb) == m_wq2);
        m_level = from_gray(m_wq2) - nb;
        m_wq2   = m_wq1;
        m_wq1   = wptr_gray_async;
        m_rbin  = nb;
        x.gray = to_gray(nb); x.addr = nb[AW-1:0]; x.empty = m_empty; x.level = m_level;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        rd_en = 1'b0; wb = '0; wptr_gray_async = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rptr_gray !== '0 || raddr !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: gray=%h addr=%h empty=%b want 0/0/1", rptr_gray, raddr, empty);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        wb = 5'd8;
        for (int i = 0; i < 8; i++) begin
            cyc(i >= 3);
            e = sb.pop_front(); checks++;
            if (rptr_gray !== e.gray || raddr !== e.addr || empty !== e.empty) begin
                errors++;
                $display("FAIL reset_stream: gray=%h addr=%h empty=%b want %h/%h/%b", rptr_gray, raddr, empty, e.gray, e.addr, e.empty);
            end
        end
        #2 rst = 1'b1;
        wb = '0; wptr_gray_async = '0; rd_en = 1'b0;
        #1;
        checks++;
        if (rptr_gray !== '0 || raddr !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: gray=%h addr=%h empty=%b want 0/0/1", rptr_gray, raddr, empty);
        end
`ifdef GRAY_RPTR_LEVEL_EN
        checks++;
        if (rd_level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d want 0", rd_level);
        end
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            e = sb.pop_front(); checks++;
            if (rptr_gray !== 5'd0 || empty !== 1'b1 || rptr_gray !== e.gray) begin
                errors++;
                $display("FAIL reset_after: gray=%h empty=%b want 00/1", rptr_gray, empty);
            end
        end
    endtask

    task automatic test_single_latency();
        logic exp_e[3] = '{1'b1, 1'b1, 1'b0};
        wb = 5'd1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            e = sb.pop_front(); checks++;
            if (empty !== exp_e[i] || empty !== e.empty) begin
                errors++;
                $display("FAIL latency_edge%0d: empty=%b want %b", i, empty, exp_e[i]);
            end
        end
        checks++;
        if (raddr !== 4'd0) begin
            errors++;
            $display("FAIL latency_raddr: got %h want 0", raddr);
        end
        cyc(1'b1);
        e = sb.pop_front(); checks++;
        if (rptr_gray !== 5'd1 || empty !== 1'b1 || raddr !== e.addr) begin
            errors++;
            $display("FAIL latency_read: gray=%h empty=%b addr=%h want 01/1/%h", rptr_gray, empty, raddr, e.addr);
        end
    endtask

    task automatic test_burst();
        pulse_reset();
        wb = 5'd16;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (raddr !== 4'(i) || empty !== 1'b0) begin
                errors++;
                $display("FAIL burst_pre%0d: addr=%h empty=%b want %h/0", i, raddr, empty, 4'(i));
            end
`ifdef GRAY_RPTR_LEVEL_EN
            checks++;
            if (rd_level !== 5'(16 - i)) begin
                errors++;
                $display("FAIL burst_level%0d: got %0d want %0d", i, rd_level, 16 - i);
            end
`endif
            cyc(1'b1);
            e = sb.pop_front(); checks++;
            if (rptr_gray !== e.gray || raddr !== e.addr || empty !== e.empty) begin
                errors++;
                $display("FAIL burst_post%0d: gray=%h addr=%h empty=%b want %h/%h/%b", i, rptr_gray, raddr, empty, e.gray, e.addr, e.empty);
            end
        end
        checks++;
        if (empty !== 1'b1 || rptr_gray !== 5'd24) begin
            errors++;
            $display("FAIL burst_end: empty=%b gray=%h want 1/18", empty, rptr_gray);
        end
`ifdef GRAY_RPTR_LEVEL_EN
        checks++;
        if (rd_level !== '0) begin
            errors++;
            $display("FAIL burst_level_end: got %0d want 0", rd_level);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [AW:0] prev;
        logic        wrapped = 1'b0;
        prev = rptr_gray;
        for (int i = 0; i < 75; i++) begin
            if (i < 40) wb = wb + 5'd1;
            cyc(i >= 40 ? 1'b1 : 1'($urandom_range(0, 1)));
            e = sb.pop_front(); checks++;
            if (rptr_gray !== e.gray || raddr !== e.addr || empty !== e.empty) begin
                errors++;
                $display("FAIL wrap_%0d: gray=%h addr=%h empty=%b want %h/%h/%b", i, rptr_gray, raddr, empty, e.gray, e.addr, e.empty);
            end
            checks++;
            if ($countones(prev ^ rptr_gray) > 1) begin
                errors++;
                $display("FAIL wrap_gray%0d: %h -> %h toggles %0d bits want <=1", i, prev, rptr_gray, $countones(prev ^ rptr_gray));
            end
            if (prev == 5'b10000 && rptr_gray == 5'b00000) wrapped = 1'b1;
            prev = rptr_gray;
        end
        checks++;
        if (wrapped !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_seen: wrapped=%b empty=%b want 1/1", wrapped, empty);
        end
    endtask

    task automatic test_read_while_empty();
        logic [AW-1:0] a0;
        logic [AW:0]   g0, pg;
        int            accepts = 0;
        a0 = raddr; g0 = rptr_gray;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            e = sb.pop_front(); checks++;
            if (raddr !== a0 || rptr_gray !== g0 || empty !== 1'b1 || rptr_gray !== e.gray) begin
                errors++;
                $display("FAIL rd_empty%0d: addr=%h gray=%h empty=%b want %h/%h/1", i, raddr, rptr_gray, empty, a0, g0);
            end
        end
        wb = wb + 5'd2;
        for (int i = 0; i < 8; i++) begin
            pg = rptr_gray;
            cyc(1'b1);
            e = sb.pop_front();
            if (rptr_gray != pg) accepts++;
        end
        checks++;
        if (accepts != 2 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rd_empty_accepts: got %0d empty=%b want 2/1", accepts, empty);
        end
    endtask

    task automatic test_simultaneous();
        wb = wb + 5'd1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            void'(sb.pop_front());
        end
        wb = wb + 5'd1;
        cyc(1'b0); void'(sb.pop_front());
        cyc(1'b0); void'(sb.pop_front());
        cyc(1'b1);
        e = sb.pop_front(); checks++;
        if (empty !== 1'b0 || empty !== e.empty || rptr_gray !== e.gray) begin
            errors++;
            $display("FAIL simul: empty=%b gray=%h want 0/%h", empty, rptr_gray, e.gray);
        end
`ifdef GRAY_RPTR_LEVEL_EN
        checks++;
        if (rd_level !== 5'd1) begin
            errors++;
            $display("FAIL simul_level: got %0d want 1", rd_level);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_burst();
        test_wrap();
        test_read_while_empty();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
